key_arbiter: RTL

Input controller in front of the 4-key code selector. Debounces the four raw push-button lines and arbitrates between simultaneous presses by fixed priority. Presents exactly one key as a one-hot select with a valid/ack handshake, so the downstream selector and consumer see one clean key event per physical press.

---
 rtl/key_arb_pkg.sv | 31 +++
 rtl/key_debounce.sv | 38 +++
 rtl/key_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/key_arb_pkg.sv
// rtl/key_arb_pkg.sv - shared types, key indices and priority helpers for key_arbiter
package key_arb_pkg;

  localparam int NUM_KEYS = 4;
  localparam int K1_IDX   = 0;
  localparam int K2_IDX   = 1;
  localparam int K3_IDX   = 2;
  localparam int K4_IDX   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // K4 wins over K3 over K2 over K1.
  function automatic logic [NUM_KEYS-1:0] pick_highest(input logic [NUM_KEYS-1:0] req);
    logic [NUM_KEYS-1:0] pick;
    pick = '0;
    if (req[K4_IDX])      pick[K4_IDX] = 1'b1;
    else if (req[K3_IDX]) pick[K3_IDX] = 1'b1;
    else if (req[K2_IDX]) pick[K2_IDX] = 1'b1;
    else if (req[K1_IDX]) pick[K1_IDX] = 1'b1;
    return pick;
  endfunction

  function automatic logic multi_hot(input logic [NUM_KEYS-1:0] v);
    return ($countones(v) > 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchronizer plus stable-count debouncer for one key
module key_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The flip happens on the edge where the counter would have reached DB_CYCLES.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_arbiter.sv
// rtl/key_arbiter.sv - debounced fixed-priority key arbiter with valid/ack handshake
module key_arbiter
  import key_arb_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                ack,
  output logic                valid,
  output logic [NUM_KEYS-1:0] sel,
  output logic                collide,
  output logic                busy,
  output logic [NUM_KEYS-1:0] keys_db
);

  arb_state_t          state;
  arb_state_t          state_nx;
  logic [NUM_KEYS-1:0] keys_db_q;
  logic [NUM_KEYS-1:0] new_press;
  logic [NUM_KEYS-1:0] sel_nx;
  logic                collide_nx;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (key_raw[i]),
      .stable (keys_db[i])
    );
  end

  assign new_press = keys_db & ~keys_db_q;
  assign valid     = (state == GRANT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      keys_db_q <= '0;
      sel       <= '0;
      collide   <= 1'b0;
    end else begin
      state     <= state_nx;
      keys_db_q <= keys_db;
      sel       <= sel_nx;
      collide   <= collide_nx;
    end
  end

  // Presses outside IDLE are dropped; RELEASE waits for every key to lift.
  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    collide_nx = collide;
    case (state)
      IDLE: begin
        if (new_press != '0) begin
          state_nx   = GRANT;
          sel_nx     = pick_highest(new_press);
          collide_nx = multi_hot(keys_db);
        end
      end
      GRANT: begin
        if (ack) begin
          state_nx   = RELEASE;
          sel_nx     = '0;
          collide_nx = 1'b0;
        end
      end
      RELEASE: begin
        if (keys_db == '0) state_nx = IDLE;
      end
      default: begin
        state_nx   = IDLE;
        sel_nx     = '0;
        collide_nx = 1'b0;
      end
    endcase
  end

endmodule
